// File: rtl/midori64_ti_pkg.sv
// rtl/midori64_ti_pkg.sv - shared constants, FSM states and unshared Q299 reference table
package midori64_ti_pkg;

    localparam int NIBBLES = 16;
    localparam int SHARE_W = 4;
    localparam int CNT_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unshared 4-bit Q299 permutation; the shared stage implements exactly this map.
    function automatic logic [3:0] q299_ref(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h8;
            4'h1: y = 4'h9;
            4'h2: y = 4'hA;
            4'h3: y = 4'hB;
            4'h4: y = 4'hE;
            4'h5: y = 4'hF;
            4'h6: y = 4'hD;
            4'h7: y = 4'hC;
            4'h8: y = 4'h5;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h7;
            4'hC: y = 4'h1;
            4'hD: y = 4'h0;
            4'hE: y = 4'h3;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/midori64_sbox_seq_stage.sv
// rtl/midori64_sbox_seq_stage.sv - one registered 3-share Q299 layer (q299_ti_stage)
module q299_ti_stage
    import midori64_ti_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [SHARE_W-1:0] in_s1,
    input  logic [SHARE_W-1:0] in_s2,
    input  logic [SHARE_W-1:0] in_s3,
    output logic               out_valid,
    output logic [SHARE_W-1:0] out_s1,
    output logic [SHARE_W-1:0] out_s2,
    output logic [SHARE_W-1:0] out_s3
);

    // Component function of the direct sharing: u is the "own" share, v the next one.
    // Each quadratic term a*b contributes ua*ub ^ ua*vb ^ va*ub, so summing the three
    // cyclic calls reproduces all nine cross products without any share seeing all three.
    // Bit 0 of v never enters a product, hence v is only bits [3:1].
    function automatic logic [3:0] q299_share(input logic [3:0] u, input logic [3:1] v);
        logic [3:0] y;
        y[0] = u[0] ^ u[3]
             ^ (u[1] & u[2]) ^ (u[1] & v[2]) ^ (v[1] & u[2])
             ^ (u[1] & u[3]) ^ (u[1] & v[3]) ^ (v[1] & u[3]);
        y[1] = u[1] ^ u[2]
             ^ (u[2] & u[3]) ^ (u[2] & v[3]) ^ (v[2] & u[3]);
        y[2] = u[2] ^ u[3];
        y[3] = ~u[3];
        return y;
    endfunction

    // Register the three output shares together with their valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s1    <= '0;
            out_s2    <= '0;
            out_s3    <= '0;
        end else begin
            out_valid <= in_valid;
            out_s1    <= q299_share(in_s2, in_s3[3:1]);
            out_s2    <= q299_share(in_s3, in_s1[3:1]);
            out_s3    <= q299_share(in_s1, in_s2[3:1]);
        end
    end

endmodule

// File: rtl/midori64_sbox_seq.sv
// rtl/midori64_sbox_seq.sv - serial 3-share Q299 S-box layer scheduler for Midori64
module midori64_sbox_seq
    import midori64_ti_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SHARE_W*NIBBLES-1:0] in_s1,
    input  logic [SHARE_W*NIBBLES-1:0] in_s2,
    input  logic [SHARE_W*NIBBLES-1:0] in_s3,
    output logic                       busy,
    output logic                       done,
    output logic [SHARE_W*NIBBLES-1:0] out_s1,
    output logic [SHARE_W*NIBBLES-1:0] out_s2,
    output logic [SHARE_W*NIBBLES-1:0] out_s3
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]           in_cnt;
    logic [CNT_W-1:0]           out_cnt;
    logic [SHARE_W*NIBBLES-1:0] sh1;
    logic [SHARE_W*NIBBLES-1:0] sh2;
    logic [SHARE_W*NIBBLES-1:0] sh3;
    logic                       accept;

    logic               pv [STAGES+1];
    logic [SHARE_W-1:0] p1 [STAGES+1];
    logic [SHARE_W-1:0] p2 [STAGES+1];
    logic [SHARE_W-1:0] p3 [STAGES+1];

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // The low nibble of each shift register is the nibble currently being fed.
    assign pv[0] = (state_q == FEED);
    assign p1[0] = sh1[SHARE_W-1:0];
    assign p2[0] = sh2[SHARE_W-1:0];
    assign p3[0] = sh3[SHARE_W-1:0];

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        q299_ti_stage u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (pv[j]),
            .in_s1     (p1[j]),
            .in_s2     (p2[j]),
            .in_s3     (p3[j]),
            .out_valid (pv[j+1]),
            .out_s1    (p1[j+1]),
            .out_s2    (p2[j+1]),
            .out_s3    (p3[j+1])
        );
    end

    // The first FEED cycle is still the acceptance cycle as seen from outside.
    assign busy = ((state_q == FEED) && (in_cnt != '0)) || (state_q == DRAIN);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: feed all nibbles, drain until the last result lands, then pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FEED;
            FEED:    if (in_cnt == LAST) state_d = DRAIN;
            DRAIN:   if (pv[STAGES] && (out_cnt == LAST)) state_d = DONE;
            DONE:    state_d = start ? FEED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, input shifting and nibble-wise output collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            sh1     <= '0;
            sh2     <= '0;
            sh3     <= '0;
            out_s1  <= '0;
            out_s2  <= '0;
            out_s3  <= '0;
        end else begin
            if (accept) begin
                sh1     <= in_s1;
                sh2     <= in_s2;
                sh3     <= in_s3;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (state_q == FEED) begin
                sh1    <= sh1 >> SHARE_W;
                sh2    <= sh2 >> SHARE_W;
                sh3    <= sh3 >> SHARE_W;
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (pv[STAGES]) begin
                out_s1[{out_cnt, 2'b00} +: SHARE_W] <= p1[STAGES];
                out_s2[{out_cnt, 2'b00} +: SHARE_W] <= p2[STAGES];
                out_s3[{out_cnt, 2'b00} +: SHARE_W] <= p3[STAGES];
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_midori64_sbox_seq.sv
// tb/tb_midori64_sbox_seq.sv - self-checking bench for midori64_sbox_seq
module tb_midori64_sbox_seq;
    import midori64_ti_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in_s1, in_s2, in_s3;
    logic        busy, done;
    logic [63:0] out_s1, out_s2, out_s3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    midori64_sbox_seq #(.STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in_s1  (in_s1),
        .in_s2  (in_s2),
        .in_s3  (in_s3),
        .busy   (busy),
        .done   (done),
        .out_s1 (out_s1),
        .out_s2 (out_s2),
        .out_s3 (out_s3)
    );

    // Two applications of the S-box layer, nibble by nibble, from the package table.
    function automatic logic [63:0] ref_layer(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  n;
        y = '0;
        for (int k = 0; k < 16; k++) begin
            n = x[4*k +: 4];
            y[4*k +: 4] = q299_ref(q299_ref(n));
        end
        return y;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    assert property (@(posedge clk) disable iff (rst) !(busy && done))
        else begin errors++; $display("FAIL onehot0_busy_done busy=%b done=%b", busy, done); end
    assert property (@(posedge clk) disable iff (rst) done |=> !done)
        else begin errors++; $display("FAIL done_pulse got done=1 expected 0"); end
    assert property (@(posedge clk) disable iff (rst)
                     !busy |=> ($stable(out_s1) && $stable(out_s2) && $stable(out_s3)))
        else begin errors++; $display("FAIL out_stable_idle outputs changed while not busy"); end

    task automatic apply_start(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        in_s1 = a; in_s2 = b; in_s3 = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        in_s1 = rnd64(); in_s2 = rnd64(); in_s3 = rnd64();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if ({out_s1, out_s2, out_s3} !== 192'd0) begin
            errors++; $display("FAIL reset_out got %h %h %h expected 0", out_s1, out_s2, out_s3);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_wins_start got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [63:0] x, exp;
        int lat, bc;
        x = 64'h0123456789ABCDEF;
        exp = ref_layer(x);
        apply_start(64'd0, 64'd0, x);
        wait_done(lat, bc);
        checks++; if (lat != 18) begin errors++; $display("FAIL basic_latency got %0d expected 18", lat); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== exp) begin
            errors++; $display("FAIL basic_result got %h expected %h", out_s1 ^ out_s2 ^ out_s3, exp);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b expected 0", done); end
    endtask

    task automatic test_random_split();
        logic [63:0] x, exp, a, b;
        int lat, bc;
        x = 64'h0123456789ABCDEF;
        exp = ref_layer(x);
        for (int i = 0; i < 100; i++) begin
            a = rnd64(); b = rnd64();
            apply_start(a, b, x ^ a ^ b);
            wait_done(lat, bc);
            checks++; if (lat != 18) begin errors++; $display("FAIL split_latency[%0d] got %0d expected 18", i, lat); end
            checks++; if (bc != 17) begin errors++; $display("FAIL split_busy_cycles[%0d] got %0d expected 17", i, bc); end
            checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== exp) begin
                errors++; $display("FAIL split_result[%0d] got %h expected %h", i, out_s1 ^ out_s2 ^ out_s3, exp);
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL split_done_width[%0d] got %b expected 0", i, done); end
        end
    endtask

    task automatic test_random_states();
        logic [63:0] x, a, b;
        int lat, bc;
        for (int i = 0; i < 20; i++) begin
            x = rnd64(); a = rnd64(); b = rnd64();
            apply_start(a, b, x ^ a ^ b);
            in_s1 = rnd64(); in_s2 = rnd64(); in_s3 = rnd64();
            wait_done(lat, bc);
            checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ref_layer(x) || lat != 18) begin
                errors++; $display("FAIL rand_state[%0d] got %h lat %0d expected %h lat 18",
                                   i, out_s1 ^ out_s2 ^ out_s3, lat, ref_layer(x));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] xa, xb, ra, rb, mix, a1, a2, b1, b2;
        int lat, bc;
        xa = rnd64(); xb = rnd64();
        ra = ref_layer(xa); rb = ref_layer(xb);
        a1 = rnd64(); a2 = rnd64(); b1 = rnd64(); b2 = rnd64();
        @(negedge clk);
        in_s1 = a1; in_s2 = a2; in_s3 = xa ^ a1 ^ a2; start = 1'b1;
        @(negedge clk);
        in_s1 = b1; in_s2 = b2; in_s3 = xb ^ b1 ^ b2;
        wait_done(lat, bc);
        checks++; if (lat != 18) begin errors++; $display("FAIL b2b_first_latency got %0d expected 18", lat); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ra) begin
            errors++; $display("FAIL b2b_first_result got %h expected %h", out_s1 ^ out_s2 ^ out_s3, ra);
        end
        @(negedge clk);
        in_s1 = rnd64(); in_s2 = rnd64(); in_s3 = rnd64();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_single_done got %b expected 0", done); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ra) begin
            errors++; $display("FAIL b2b_hold got %h expected %h", out_s1 ^ out_s2 ^ out_s3, ra);
        end
        repeat (10) @(negedge clk);
        for (int k = 0; k < 16; k++) mix[4*k +: 4] = (k <= 7) ? rb[4*k +: 4] : ra[4*k +: 4];
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== mix) begin
            errors++; $display("FAIL b2b_partial got %h expected %h", out_s1 ^ out_s2 ^ out_s3, mix);
        end
        wait_done(lat, bc);
        checks++; if (lat + 10 != 18) begin errors++; $display("FAIL b2b_second_latency got %0d expected 18", lat + 10); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== rb) begin
            errors++; $display("FAIL b2b_second_result got %h expected %h", out_s1 ^ out_s2 ^ out_s3, rb);
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_return_idle got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] x, a, b;
        int lat, bc;
        x = rnd64(); a = rnd64(); b = rnd64();
        apply_start(a, b, x ^ a ^ b);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b expected 0", done); end
        checks++; if ({out_s1, out_s2, out_s3} !== 192'd0) begin
            errors++; $display("FAIL midrst_out got %h %h %h expected 0", out_s1, out_s2, out_s3);
        end
        x = rnd64(); a = rnd64(); b = rnd64();
        apply_start(a, b, x ^ a ^ b);
        wait_done(lat, bc);
        checks++; if (lat != 18) begin errors++; $display("FAIL midrst_latency got %0d expected 18", lat); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ref_layer(x)) begin
            errors++; $display("FAIL midrst_result got %h expected %h", out_s1 ^ out_s2 ^ out_s3, ref_layer(x));
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] x, a, b;
        int ndone, first;
        x = rnd64(); a = rnd64(); b = rnd64();
        apply_start(a, b, x ^ a ^ b);
        in_s1 = rnd64(); in_s2 = rnd64(); in_s3 = rnd64();
        ndone = 0; first = -1;
        for (int c = 0; c < 40; c++) begin
            start = (c == 3 || c == 10);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d expected 1", ndone); end
        checks++; if (first != 18) begin errors++; $display("FAIL busy_start_latency got %0d expected 18", first); end
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ref_layer(x)) begin
            errors++; $display("FAIL busy_start_result got %h expected %h", out_s1 ^ out_s2 ^ out_s3, ref_layer(x));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        in_s1 = '0; in_s2 = '0; in_s3 = '0;
        test_reset();
        test_basic();
        test_random_split();
        test_random_states();
        test_back_to_back();
        test_reset_mid();
        test_start_while_busy();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
